// File: rtl/wam_pkg.sv
// Shared difficulty tables and limits for the whack-a-mole difficulty controller.
// Levels beyond the table fall back to a fixed default lifetime/ratio pair.
package wam_pkg;

  localparam int MAX_NLVL = 16;
  localparam int TBL_LEN  = 11;

  localparam logic [3:0] DEF_AGE = 4'd7;
  localparam logic [7:0] DEF_RTO = 8'd70;

  localparam logic [3:0] AGE_TBL [TBL_LEN] = '{
    4'd14, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2
  };

  localparam logic [7:0] RTO_TBL [TBL_LEN] = '{
    8'd42, 8'd62, 8'd76, 8'd87, 8'd93, 8'd96, 8'd93, 8'd87, 8'd76, 8'd61, 8'd93
  };

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  function automatic logic [3:0] age_lut(input logic [3:0] lvl);
    if (lvl < 4'(TBL_LEN)) return AGE_TBL[lvl];
    return DEF_AGE;
  endfunction

  function automatic logic [7:0] rto_lut(input logic [3:0] lvl);
    if (lvl < 4'(TBL_LEN)) return RTO_TBL[lvl];
    return DEF_RTO;
  endfunction

endpackage

// File: rtl/wam_edge.sv
// Rising-edge detector for a level-held button. The history flop resets high so a
// button held through reset release does not register as a press.
module wam_edge (
  input  logic clk,
  input  logic clr,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) in_q <= 1'b1;
    else     in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/wam_diff_ctl.sv
// Difficulty level controller: buttons and hit/miss streaks move a saturating level.
// Define WAM_DIFF_AUTO_EASE_EN to build the miss-streak counter that lowers the level.
module wam_diff_ctl
  import wam_pkg::*;
#(
  parameter int NLVL        = 11,
  parameter int LW          = 4,
  parameter int HIT_STREAK  = 4,
  parameter int MISS_STREAK = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          lft,
  input  logic          rgt,
  input  logic          hit,
  input  logic          miss,
  output logic [LW-1:0] hrdn,
  output logic [3:0]    age,
  output logic [7:0]    rto,
  output logic          lvl_chg,
  output logic          at_max,
  output logic          at_min
);

  if (NLVL < 2 || NLVL > MAX_NLVL || LW != $clog2(NLVL) ||
      HIT_STREAK < 1 || HIT_STREAK > 15 || MISS_STREAK < 1 || MISS_STREAK > 15) begin : g_bad_cfg
    $error("wam_diff_ctl: illegal parameter combination");
  end

  logic          lft_rise, rgt_rise;
  logic          hit_v, miss_v, btn_edge;
  logic          hit_done, miss_done;
  logic          up_req, down_req;
  dir_e          dir;
  logic [3:0]    hit_cnt_q, hit_cnt_d;
  logic [LW-1:0] hrdn_q, hrdn_d;
  logic [3:0]    age_q;
  logic [7:0]    rto_q;
  logic          lvl_chg_q, at_max_q, at_min_q;
  logic [3:0]    lvl4_d;

  wam_edge u_lft_edge (.clk(clk), .clr(clr), .in(lft), .rise(lft_rise));
  wam_edge u_rgt_edge (.clk(clk), .clr(clr), .in(rgt), .rise(rgt_rise));

  // Simultaneous hit and miss is treated as noise; a button press restarts both streaks.
  assign hit_v    = hit & ~miss;
  assign miss_v   = miss & ~hit;
  assign btn_edge = lft_rise | rgt_rise;

  always_comb begin
    hit_done  = 1'b0;
    hit_cnt_d = hit_cnt_q;
    if (hit_v) begin
      if (hit_cnt_q == 4'(HIT_STREAK - 1)) begin
        hit_done  = 1'b1;
        hit_cnt_d = '0;
      end else begin
        hit_cnt_d = hit_cnt_q + 4'd1;
      end
    end
    if (miss_v)   hit_cnt_d = '0;
    if (btn_edge) hit_cnt_d = '0;
  end

`ifdef WAM_DIFF_AUTO_EASE_EN
  logic [3:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    miss_done  = 1'b0;
    miss_cnt_d = miss_cnt_q;
    if (miss_v) begin
      if (miss_cnt_q == 4'(MISS_STREAK - 1)) begin
        miss_done  = 1'b1;
        miss_cnt_d = '0;
      end else begin
        miss_cnt_d = miss_cnt_q + 4'd1;
      end
    end
    if (hit_v)    miss_cnt_d = '0;
    if (btn_edge) miss_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) miss_cnt_q <= '0;
    else     miss_cnt_q <= miss_cnt_d;
  end
`else
  assign miss_done = 1'b0;
`endif

  assign up_req   = rgt_rise | hit_done;
  assign down_req = lft_rise | miss_done;

  always_comb begin
    dir = DIR_HOLD;
    if (up_req && !down_req)      dir = DIR_UP;
    else if (down_req && !up_req) dir = DIR_DOWN;
    hrdn_d = hrdn_q;
    case (dir)
      DIR_UP:   if (hrdn_q != LW'(NLVL - 1)) hrdn_d = hrdn_q + 1'b1;
      DIR_DOWN: if (hrdn_q != '0)            hrdn_d = hrdn_q - 1'b1;
      default:  hrdn_d = hrdn_q;
    endcase
    lvl4_d = 4'(hrdn_d);
  end

  // Table outputs are looked up from the next level so they move together with hrdn.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hit_cnt_q <= '0;
      hrdn_q    <= '0;
      age_q     <= age_lut(4'd0);
      rto_q     <= rto_lut(4'd0);
      lvl_chg_q <= 1'b0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b1;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      hrdn_q    <= hrdn_d;
      age_q     <= age_lut(lvl4_d);
      rto_q     <= rto_lut(lvl4_d);
      lvl_chg_q <= (hrdn_d != hrdn_q);
      at_max_q  <= (hrdn_d == LW'(NLVL - 1));
      at_min_q  <= (hrdn_d == '0);
    end
  end

  assign hrdn    = hrdn_q;
  assign age     = age_q;
  assign rto     = rto_q;
  assign lvl_chg = lvl_chg_q;
  assign at_max  = at_max_q;
  assign at_min  = at_min_q;

endmodule

// File: tb/tb_wam_diff_ctl.sv
// Self-checking bench for wam_diff_ctl: directed scenarios plus a randomized run,
// all compared every cycle against a level/streak reference model.
module tb_wam_diff_ctl;

  localparam int NLVL        = 11;
  localparam int LW          = 4;
  localparam int HIT_STREAK  = 4;
  localparam int MISS_STREAK = 3;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          lftIn = 1'b0, rgtIn = 1'b0, hitIn = 1'b0, missIn = 1'b0;
  logic [LW-1:0] hrdn;
  logic [3:0]    age;
  logic [7:0]    rto;
  logic          lvlChg, atMax, atMin;

  int nCompared   = 0;
  int nMismatched = 0;
  int pulseCnt    = 0;

  int ageTab [16] = '{14, 11, 9, 7, 6, 5, 4, 4, 3, 3, 2, 7, 7, 7, 7, 7};
  int rtoTab [16] = '{42, 62, 76, 87, 93, 96, 93, 87, 76, 61, 93, 70, 70, 70, 70, 70};

  // Reference model state
  int mLevel   = 0;
  int mHits    = 0;
  int mMisses  = 0;
  bit mPrevL   = 1'b1;
  bit mPrevR   = 1'b1;
  bit mChg     = 1'b0;

  wam_diff_ctl #(
    .NLVL(NLVL), .LW(LW), .HIT_STREAK(HIT_STREAK), .MISS_STREAK(MISS_STREAK)
  ) dut (
    .clk(clk), .clr(clr), .lft(lftIn), .rgt(rgtIn), .hit(hitIn), .miss(missIn),
    .hrdn(hrdn), .age(age), .rto(rto), .lvl_chg(lvlChg), .at_max(atMax), .at_min(atMin)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mLevel  = 0;
    mHits   = 0;
    mMisses = 0;
    mPrevL  = 1'b1;
    mPrevR  = 1'b1;
    mChg    = 1'b0;
  endtask

  task automatic modelStep();
    bit lEdge, rEdge, up, down;
    int oldLevel;
    lEdge  = lftIn && !mPrevL;
    rEdge  = rgtIn && !mPrevR;
    mPrevL = lftIn;
    mPrevR = rgtIn;
    up     = rEdge;
    down   = lEdge;
    if (hitIn && !missIn) begin
      mHits++;
      mMisses = 0;
      if (mHits == HIT_STREAK) begin
        up    = 1'b1;
        mHits = 0;
      end
    end else if (missIn && !hitIn) begin
      mHits = 0;
`ifdef WAM_DIFF_AUTO_EASE_EN
      mMisses++;
      if (mMisses == MISS_STREAK) begin
        down    = 1'b1;
        mMisses = 0;
      end
`endif
    end
    if (lEdge || rEdge) begin
      mHits   = 0;
      mMisses = 0;
    end
    oldLevel = mLevel;
    if (up && !down && mLevel < NLVL - 1) mLevel++;
    else if (down && !up && mLevel > 0)   mLevel--;
    mChg = (mLevel != oldLevel);
  endtask

  // Model advances and the DUT is compared one time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    if (clr) modelReset();
    else     modelStep();
    checkVal("hrdn",    int'(hrdn),   mLevel);
    checkVal("age",     int'(age),    ageTab[mLevel]);
    checkVal("rto",     int'(rto),    rtoTab[mLevel]);
    checkVal("lvl_chg", int'(lvlChg), int'(mChg));
    checkVal("at_max",  int'(atMax),  int'(mLevel == NLVL - 1));
    checkVal("at_min",  int'(atMin),  int'(mLevel == 0));
    if (lvlChg) pulseCnt++;
  end

  task automatic applyStimulus(input bit l, input bit r, input bit h, input bit m);
    @(negedge clk);
    lftIn  = l;
    rgtIn  = r;
    hitIn  = h;
    missIn = m;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pressRight(input int hold);
    for (int i = 0; i < hold; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic pressLeft(input int hold);
    for (int i = 0; i < hold; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic hitPulses(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checkVal(name, act, exp);
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    clr = 1'b0;
    idle(3);
    checkOutput("reset_hrdn", int'(hrdn), 0);
    checkOutput("reset_age", int'(age), 14);
    checkOutput("reset_rto", int'(rto), 42);
    checkOutput("reset_at_min", int'(atMin), 1);

    // Three held right presses
    pulseCnt = 0;
    for (int p = 0; p < 3; p++) pressRight(5);
    checkOutput("rgt3_hrdn", int'(hrdn), 3);
    checkOutput("rgt3_age", int'(age), 7);
    checkOutput("rgt3_rto", int'(rto), 87);
    checkOutput("rgt3_pulses", pulseCnt, 3);

    // Saturation at the bottom
    pulseReset();
    idle(1);
    pulseCnt = 0;
    pressLeft(3);
    checkOutput("min_sat_hrdn", int'(hrdn), 0);
    checkOutput("min_sat_pulses", pulseCnt, 0);

    // Saturation at the top
    for (int p = 0; p < NLVL - 1; p++) pressRight(1);
    checkOutput("top_hrdn", int'(hrdn), 10);
    checkOutput("top_at_max", int'(atMax), 1);
    pulseCnt = 0;
    pressRight(2);
    checkOutput("max_sat_hrdn", int'(hrdn), 10);
    checkOutput("max_sat_pulses", pulseCnt, 0);

    // Hit streak raises the level on the fourth hit's edge
    pulseReset();
    idle(1);
    pressRight(1);
    pressRight(1);
    hitPulses(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("hit4_hrdn", int'(hrdn), 3);
    checkOutput("hit4_chg", int'(lvlChg), 1);
    idle(1);
    hitPulses(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    hitPulses(3);
    checkOutput("hit_miss_hit_hrdn", int'(hrdn), 3);

    // Right edge coinciding with fourth hit gives a single step
    pulseReset();
    idle(1);
    hitPulses(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rgt_hit_hrdn", int'(hrdn), 1);
    idle(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rgt_lft_hrdn", int'(hrdn), 1);
    checkOutput("rgt_lft_chg", int'(lvlChg), 0);
    idle(2);

    // Button held through reset release is not a press
    @(negedge clk);
    rgtIn = 1'b1;
    pulseReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("held_rgt_hrdn", int'(hrdn), 0);
    idle(2);

    // Reset mid-streak discards partial hits
    hitPulses(3);
    pulseReset();
    hitPulses(1);
    checkOutput("mid_reset_hrdn", int'(hrdn), 0);

    // Miss streak behaviour at level 5
    for (int p = 0; p < 5; p++) pressRight(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
`ifdef WAM_DIFF_AUTO_EASE_EN
    checkOutput("miss3_hrdn", int'(hrdn), 4);
    checkOutput("miss3_age", int'(age), 6);
    checkOutput("miss3_rto", int'(rto), 93);
`else
    checkOutput("miss3_hrdn", int'(hrdn), 5);
    checkOutput("miss3_age", int'(age), 5);
    checkOutput("miss3_rto", int'(rto), 96);
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulseReset();
      end else begin
        bit l, r, h, m;
        l = ($urandom_range(0, 5) == 0) ? ~lftIn : lftIn;
        r = ($urandom_range(0, 5) == 0) ? ~rgtIn : rgtIn;
        h = ($urandom_range(0, 99) < 35);
        m = ($urandom_range(0, 99) < 25);
        applyStimulus(l, r, h, m);
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/wam_diff_ctl.md
WAM_DIFF_CTL -- requirements
Module: wam_diff_ctl

Interface
REQ-001 SHALL have parameter NLVL, default 11, number of difficulty levels, legal 2..16.
REQ-002 SHALL have parameter LW, default 4, level width; LW SHALL equal ceil(log2(NLVL)).
REQ-003 SHALL have parameter HIT_STREAK, default 4, consecutive hits that raise the level, legal 1..15.
REQ-004 SHALL have parameter MISS_STREAK, default 3, consecutive misses that lower the level, legal 1..15.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 lft  in  1  "easier" button, level-held; acts on rising edge only.
REQ-008 rgt  in  1  "harder" button, level-held; acts on rising edge only.
REQ-009 hit  in  1  single-cycle pulse; player hit a mole.
REQ-010 miss  in  1  single-cycle pulse; mole expired unhit.
REQ-011 hrdn  out  LW  current level, 0..NLVL-1.
REQ-012 age  out  4  mole lifetime for current level.
REQ-013 rto  out  8  spawn ratio (percent) for current level.
REQ-014 lvl_chg  out  1  one-cycle pulse when hrdn changed on this edge.
REQ-015 at_max / at_min  out  1 each  hrdn==NLVL-1 / hrdn==0.

Function
REQ-016 Edges SHALL be detected as x & ~x_q, where x_q is the previous-cycle sample of lft or rgt.
REQ-017 The up request SHALL be rgt edge OR hit-streak completion; the down request SHALL be lft edge OR miss-streak completion.
REQ-018 A request SHALL update hrdn on the same clock edge it is detected (latency 1 cycle).
REQ-019 Up and down requests in the same cycle SHALL cancel; hrdn SHALL be unchanged and lvl_chg SHALL be 0.
REQ-020 hrdn SHALL saturate at 0 and NLVL-1; a saturated request SHALL leave hrdn unchanged, with no lvl_chg pulse.
REQ-021 hit_cnt SHALL count hits; when it reaches HIT_STREAK it SHALL issue an up request and clear to 0 in the same cycle.
REQ-022 A miss SHALL clear hit_cnt.
REQ-023 A hit SHALL clear miss_cnt.
REQ-024 hit and miss asserted in the same cycle SHALL be ignored, and both counters SHALL hold.
REQ-025 Any lft or rgt edge SHALL clear both streak counters.
REQ-026 age and rto SHALL be registered and SHALL track the next hrdn value, so that all three outputs change on the same edge.
REQ-027 Table lookup by level 0..10:
- age = 14,11,9,7,6,5,4,4,3,3,2
- rto = 42,62,76,87,93,96,93,87,76,61,93
- levels 11..15: age=7, rto=70.

Reset
REQ-028 clr SHALL force hrdn=0, age=14, rto=42, lvl_chg=0, at_min=1, at_max=0, with both counters cleared.
REQ-029 clr SHALL set lft_q and rgt_q to 1, so a button held through reset release produces no edge.
REQ-030 clr asserted mid-operation SHALL discard any pending streak state immediately.

Configuration
REQ-031 With WAM_DIFF_AUTO_EASE_EN defined, miss_cnt SHALL exist; reaching MISS_STREAK SHALL issue a down request and clear miss_cnt.
REQ-032 Without WAM_DIFF_AUTO_EASE_EN, no miss counter SHALL be built, and miss SHALL only clear hit_cnt.

Structure
REQ-033 The age/rto tables, default entry and level-count limit SHALL reside in package wam_pkg.
REQ-034 Edge detection SHALL be the sub-module wam_edge (clk, clr, in, rise), instantiated twice.

Verification
REQ-035 clr pulse, then idle -> hrdn=0, age=14, rto=42, at_min=1.
REQ-036 Three rgt presses, each held 5 cycles -> hrdn=3, age=7, rto=87, exactly three lvl_chg pulses.
REQ-037 At hrdn=0, press lft -> hrdn=0, no lvl_chg. At hrdn=10, NLVL=11, press rgt -> hrdn=10, no lvl_chg.
REQ-038 Four hit pulses at hrdn=2 -> hrdn=3 on the 4th hit's edge. Sequence 3 hits, miss, 3 hits -> hrdn unchanged.
REQ-039 WAM_DIFF_AUTO_EASE_EN on, hrdn=5, three miss pulses -> hrdn=4, age=6, rto=93. Macro off -> hrdn stays 5.
REQ-040 rgt edge and 4th hit in the same cycle -> one increment. rgt and lft edges in the same cycle -> no change.
